// File: rtl/dest_reg_pipe.sv
// Destination-register pipeline: decodes a one-hot opcode into a write
// destination (RD or RS2), carries it through DEPTH stages with stall/flush,
// and flags RAW hazards against two source addresses.
module dest_reg_pipe #(
  parameter int unsigned    AW         = 5,
  parameter int unsigned    OPW        = 20,
  parameter int unsigned    DEPTH      = 4,
  parameter logic [OPW-1:0] SEL_A_MASK = 20'hC0073,
  parameter logic [OPW-1:0] SEL_B_MASK = 20'h03F8C,
  parameter logic [OPW-1:0] WE_MASK    = 20'hC3FFF,
  parameter bit             ZERO_REG   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [OPW-1:0]      in_op,
  input  logic [AW-1:0]       in_rd,
  input  logic [AW-1:0]       in_rs2,
  input  logic                stall,
  input  logic                flush,
  input  logic [AW-1:0]       src_a,
  input  logic [AW-1:0]       src_b,
  output logic [DEPTH*AW-1:0] dst_addr,
  output logic [DEPTH-1:0]    dst_we,
  output logic [DEPTH-1:0]    dst_valid,
  output logic [AW-1:0]       wb_addr,
  output logic                wb_we,
  output logic [DEPTH-1:0]    haz_a,
  output logic [DEPTH-1:0]    haz_b,
  output logic                illegal_op
);

  logic                    match_a_c;
  logic                    match_b_c;
  logic                    onehot_c;
  logic                    illegal_c;
  logic                    accept_c;
  logic [AW-1:0]           sel_addr_c;
  logic                    sel_we_c;

  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0]         we_q, we_d;
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic                     illegal_q, illegal_d;

  // Opcode decode: pick destination field, write-enable and legality
  always_comb begin
    match_a_c  = |(in_op & SEL_A_MASK);
    match_b_c  = |(in_op & SEL_B_MASK);
    onehot_c   = (in_op != '0) && ((in_op & (in_op - OPW'(1))) == '0);
    illegal_c  = ~onehot_c | ~(match_a_c | match_b_c);
    sel_addr_c = '0;
    if (match_a_c) begin
      sel_addr_c = in_rd;
    end else if (match_b_c) begin
      sel_addr_c = in_rs2;
    end
    sel_we_c = |(in_op & WE_MASK) & (match_a_c | match_b_c) & ~illegal_c;
    if (ZERO_REG && (sel_addr_c == '0)) begin
      sel_we_c = 1'b0;
    end
    accept_c = in_valid & ~stall & ~flush;
  end

  // Next-state for the stage registers: accept/hold/bubble at stage 0, shift beyond
  always_comb begin
    addr_d    = addr_q;
    we_d      = we_q;
    valid_d   = valid_q;
    illegal_d = accept_c & illegal_c;

    if (flush) begin
      addr_d[0]  = '0;
      we_d[0]    = 1'b0;
      valid_d[0] = 1'b0;
    end else if (stall) begin
      addr_d[0]  = addr_q[0];
      we_d[0]    = we_q[0];
      valid_d[0] = valid_q[0];
    end else if (accept_c) begin
      addr_d[0]  = sel_addr_c;
      we_d[0]    = sel_we_c;
      valid_d[0] = 1'b1;
    end else begin
      addr_d[0]  = '0;
      we_d[0]    = 1'b0;
      valid_d[0] = 1'b0;
    end

    for (int unsigned k = 1; k < DEPTH; k++) begin
      if ((k == 1) && (stall || flush)) begin
        addr_d[k]  = '0;
        we_d[k]    = 1'b0;
        valid_d[k] = 1'b0;
      end else begin
        addr_d[k]  = addr_q[k-1];
        we_d[k]    = we_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  // Stage registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      we_q      <= '0;
      valid_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      we_q      <= we_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  // RAW hazard flags from the registered stages; address 0 never hazards when hardwired
  always_comb begin
    haz_a = '0;
    haz_b = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      haz_a[k] = valid_q[k] & we_q[k] & (addr_q[k] == src_a) &
                 ~(ZERO_REG && (src_a == '0));
      haz_b[k] = valid_q[k] & we_q[k] & (addr_q[k] == src_b) &
                 ~(ZERO_REG && (src_b == '0));
    end
  end

  assign dst_addr   = addr_q;
  assign dst_we     = we_q;
  assign dst_valid  = valid_q;
  assign wb_addr    = addr_q[DEPTH-1];
  assign wb_we      = we_q[DEPTH-1] & valid_q[DEPTH-1];
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Directed self-checking bench for dest_reg_pipe with default parameters.
module tb_dest_reg_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [19:0] in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs2;
  logic        stall;
  logic        flush;
  logic [4:0]  src_a;
  logic [4:0]  src_b;
  logic [19:0] dst_addr;
  logic [3:0]  dst_we;
  logic [3:0]  dst_valid;
  logic [4:0]  wb_addr;
  logic        wb_we;
  logic [3:0]  haz_a;
  logic [3:0]  haz_b;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  dest_reg_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs2     (in_rs2),
    .stall      (stall),
    .flush      (flush),
    .src_a      (src_a),
    .src_b      (src_b),
    .dst_addr   (dst_addr),
    .dst_we     (dst_we),
    .dst_valid  (dst_valid),
    .wb_addr    (wb_addr),
    .wb_we      (wb_we),
    .haz_a      (haz_a),
    .haz_b      (haz_b),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [19:0] op, input logic [4:0] rd,
                       input logic [4:0] rs2);
    in_valid = v;
    in_op    = op;
    in_rd    = rd;
    in_rs2   = rs2;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    src_a = 5'd0;
    src_b = 5'd0;
    drive(1'b0, 20'h0, 5'd0, 5'd0);
    step();
    step();
    rst = 1'b0;
    check("reset_valid", 32'(dst_valid), 32'h0);
    check("reset_we", 32'(dst_we), 32'h0);
    check("reset_addr", 32'(dst_addr), 32'h0);
    check("reset_illegal", 32'(illegal_op), 32'h0);
    check("reset_wb_we", 32'(wb_we), 32'h0);

    // ADD rd=7: stage 0 after 1 edge, WB after 4
    drive(1'b1, 20'h00001, 5'd7, 5'd3);
    step();
    drive(1'b0, 20'h0, 5'd0, 5'd0);
    check("add_s0_addr", 32'(dst_addr[4:0]), 32'd7);
    check("add_s0_we", 32'(dst_we[0]), 32'd1);
    check("add_valid", 32'(dst_valid), 32'h1);
    step();
    step();
    step();
    check("add_wb_addr", 32'(wb_addr), 32'd7);
    check("add_wb_we", 32'(wb_we), 32'd1);
    check("add_valid_s3", 32'(dst_valid), 32'h8);

    // ADDI rs2=12 then SUB rd=4 back to back
    drive(1'b1, 20'h00800, 5'd9, 5'd12);
    step();
    drive(1'b1, 20'h00002, 5'd4, 5'd1);
    step();
    drive(1'b0, 20'h0, 5'd0, 5'd0);
    check("b2b_s0", 32'(dst_addr[4:0]), 32'd4);
    check("b2b_s1", 32'(dst_addr[9:5]), 32'd12);
    step();
    step();
    check("b2b_wb0_addr", 32'(wb_addr), 32'd12);
    check("b2b_wb0_we", 32'(wb_we), 32'd1);
    step();
    check("b2b_wb1_addr", 32'(wb_addr), 32'd4);
    check("b2b_wb1_we", 32'(wb_we), 32'd1);
    step();
    step();
    step();
    step();
    check("drained", 32'(dst_valid), 32'h0);

    // Stall two cycles with ADD rd=10 in stage 0, SUB rd=4 ahead of it
    drive(1'b1, 20'h00002, 5'd4, 5'd0);
    step();
    drive(1'b1, 20'h00001, 5'd10, 5'd0);
    step();
    drive(1'b1, 20'h00001, 5'd15, 5'd0);
    stall = 1'b1;
    step();
    check("stall1_s0", 32'(dst_addr[4:0]), 32'd10);
    check("stall1_valid", 32'(dst_valid), 32'h5);
    check("stall1_s2", 32'(dst_addr[14:10]), 32'd4);
    step();
    check("stall2_s0", 32'(dst_addr[4:0]), 32'd10);
    check("stall2_valid", 32'(dst_valid), 32'h9);
    check("stall2_wb_addr", 32'(wb_addr), 32'd4);
    stall = 1'b0;
    drive(1'b0, 20'h0, 5'd0, 5'd0);
    step();
    check("unstall_valid", 32'(dst_valid), 32'h2);
    check("unstall_s1", 32'(dst_addr[9:5]), 32'd10);
    step();
    check("unstall_wb_early", 32'(wb_we), 32'd0);
    step();
    check("stall_late_wb_addr", 32'(wb_addr), 32'd10);
    check("stall_late_wb_we", 32'(wb_we), 32'd1);

    // Flush + stall with stages 0/1 valid
    drive(1'b1, 20'h00001, 5'd5, 5'd0);
    step();
    drive(1'b1, 20'h00001, 5'd6, 5'd0);
    step();
    drive(1'b1, 20'h00001, 5'd9, 5'd0);
    flush = 1'b1;
    stall = 1'b1;
    step();
    flush = 1'b0;
    stall = 1'b0;
    check("flush_valid", 32'(dst_valid), 32'h4);
    check("flush_s2", 32'(dst_addr[14:10]), 32'd5);
    check("flush_s01_addr", 32'(dst_addr[9:0]), 32'd0);

    // Hazards: ADD rd=6 reaches stage 2, ADD rd=0 in stage 1
    drive(1'b1, 20'h00001, 5'd6, 5'd0);
    step();
    drive(1'b1, 20'h00001, 5'd0, 5'd0);
    step();
    drive(1'b0, 20'h0, 5'd0, 5'd0);
    step();
    src_a = 5'd6;
    src_b = 5'd0;
    #1;
    check("haz_valid", 32'(dst_valid), 32'h6);
    check("haz_we", 32'(dst_we), 32'h4);
    check("haz_a", 32'(haz_a), 32'h4);
    check("haz_b_zero", 32'(haz_b), 32'h0);
    check("haz_illegal", 32'(illegal_op), 32'd0);
    src_a = 5'd5;
    src_b = 5'd6;
    #1;
    check("haz_a_none", 32'(haz_a), 32'h0);
    check("haz_b_six", 32'(haz_b), 32'h4);

    // Illegal opcodes: two bits set, then none
    drive(1'b1, 20'h00003, 5'd8, 5'd2);
    step();
    drive(1'b0, 20'h0, 5'd0, 5'd0);
    check("ill2_pulse", 32'(illegal_op), 32'd1);
    check("ill2_valid", 32'(dst_valid[0]), 32'd1);
    check("ill2_we", 32'(dst_we[0]), 32'd0);
    step();
    check("ill2_pulse_end", 32'(illegal_op), 32'd0);
    drive(1'b1, 20'h00000, 5'd8, 5'd2);
    step();
    drive(1'b0, 20'h0, 5'd0, 5'd0);
    check("ill0_pulse", 32'(illegal_op), 32'd1);
    check("ill0_valid", 32'(dst_valid[0]), 32'd1);
    check("ill0_we", 32'(dst_we[0]), 32'd0);
    check("ill0_addr", 32'(dst_addr[4:0]), 32'd0);
    step();
    check("ill0_pulse_end", 32'(illegal_op), 32'd0);

    // Reset overrides stall, flush and a valid instruction
    drive(1'b1, 20'h00001, 5'd3, 5'd0);
    stall = 1'b1;
    rst = 1'b1;
    step();
    check("rst_override_valid", 32'(dst_valid), 32'h0);
    check("rst_override_addr", 32'(dst_addr), 32'h0);
    rst = 1'b0;
    stall = 1'b0;
    drive(1'b0, 20'h0, 5'd0, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dest_reg_pipe.md
Name: dest_reg_pipe

Overview:
- Parametrised successor to the one-hot destination-register mux.
- Decodes the one-hot opcode vector and picks the write-destination register address: RD for R-type/FP ops, RS2 for immediate/load ops.
- The result, plus its write-enable, travels through a DEPTH-stage register pipeline (ID→EX→MEM→WB) with stall and flush support.
- Per-stage RAW hazard flags are produced for two source addresses; the WB-stage address/enable feed the register file.

Parameters:
- AW, 5, register address width
- OPW, 20, one-hot opcode vector width
- DEPTH, 4, pipeline stages carrying destination info (min 1)
- SEL_A_MASK, 20'hC0073, opcode bits selecting in_rd (ADD, SUB, SGE, SLE, SEQ, ADDF, MULF)
- SEL_B_MASK, 20'h03F8C, opcode bits selecting in_rs2 (LOAD, STORE, SLI, SRI, ADDI, SUBI, NOP)
- WE_MASK, 20'hC3FFF, opcode bits that write the register file; integrator clears STORE/NOP bits
- ZERO_REG, 1, 1 = address 0 is hardwired and never writes or hazards

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decoded instruction present
- in_op  in  OPW  one-hot opcode vector
- in_rd  in  AW  RD field
- in_rs2  in  AW  RS2 field
- stall  in  1  freeze stage 0, bubble into stage 1
- flush  in  1  kill stages 0 and 1
- src_a  in  AW  source address A for hazard check
- src_b  in  AW  source address B for hazard check
- dst_addr  out  DEPTH*AW  per-stage destination, stage k at [k*AW +: AW]
- dst_we  out  DEPTH  per-stage write-enable
- dst_valid  out  DEPTH  per-stage valid
- wb_addr  out  AW  equals stage DEPTH-1 address
- wb_we  out  1  dst_we[DEPTH-1] & dst_valid[DEPTH-1]
- haz_a  out  DEPTH  src_a matches stage k destination
- haz_b  out  DEPTH  src_b matches stage k destination
- illegal_op  out  1  registered one-cycle pulse

Behaviour:
- Reset (rst=1 at a clk edge): all dst_addr, dst_we, dst_valid = 0; illegal_op = 0. Reset overrides stall and flush.
- Selection (combinational, input side):
  - match_a = |(in_op & SEL_A_MASK); match_b = |(in_op & SEL_B_MASK).
  - match_a selects in_rd; otherwise match_b selects in_rs2. A has priority over B.
  - No match: address = 0, we = 0. No latch inference; every path is assigned.
  - we = |(in_op & WE_MASK) & (match_a | match_b); forced to 0 if ZERO_REG and address == 0.
- Accept: in_valid & ~stall & ~flush. On accept, stage 0 loads {addr, we, valid=1}. If not accepting and not stalled, stage 0 loads a bubble (valid=0, we=0, addr=0).
- Latency: an instruction accepted at edge N is visible in stage k after edge N+k; it reaches wb_* DEPTH-1 cycles after stage 0.
- Advance: stages 1..DEPTH-1 copy the previous stage every cycle.
- Stall (flush=0):
  - Stage 0 holds its contents.
  - Stage 1 loads a bubble.
  - Stages 2 and above keep shifting.
  - If DEPTH=1, stage 0 simply holds.
- Flush: stages 0 and 1 load bubbles; stages 2 and above shift. Flush wins over stall and in_valid.
- Hazards (combinational from registers): haz_a[k] = dst_valid[k] & dst_we[k] & (dst_addr[k] == src_a) & ~(ZERO_REG & src_a == 0). haz_b is identical using src_b.
- illegal_op: registered pulse, high the cycle after an accept where in_op is not exactly one-hot or matches neither mask. The instruction still enters as valid with we=0.

Test Plan:
- Reset then ADD (in_op=20'h00001, rd=5'd7, rs2=5'd3) → stage0 addr=7, we=1, valid=1 after 1 edge; wb_addr=7, wb_we=1 after 4 edges.
- ADDI (in_op=20'h00800, rd=9, rs2=12) back-to-back with SUB (20'h00002, rd=4) → wb_addr sequence 12 then 4 on consecutive cycles.
- Stall 2 cycles with ADD rd=10 held in stage 0 → stage 0 stays 10; dst_valid[1]=0 for 2 cycles; entry reaches WB 2 cycles late; stages 2–3 drain meanwhile.
- Flush and stall asserted together with stages 0/1 valid → both become bubbles next edge; stage 2 receives the old stage 1 contents.
- ADD rd=6 in stage 2, src_a=6, src_b=0; also ADD rd=0 → haz_a=4'b0100, haz_b=4'b0000; the rd=0 entry has we=0.
- in_op=20'h00003 (two bits set) → illegal_op pulses one cycle; stage0 valid=1, we=0. in_op=20'h00000 → same response.
